// File: rtl/mult_pkg.sv
// Shared types and helpers for the sequential multiplier.
// State encoding and counter sizing live here so every unit agrees.
package mult_pkg;

    typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t;

    // Bit-counter width: enough to hold W-1, never narrower than one bit.
    function automatic int cnt_w(input int w);
        return ($clog2(w) < 1) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/mult_seq_if.sv
// Operand/result handshake bundle for mult_seq.
// The master drives operands and takes results; the slave is the multiplier.
interface mult_seq_if #(parameter int W = 8);

    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             is_signed;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   y;

    modport master (
        output in_valid, a, b, is_signed, out_ready,
        input  in_ready, out_valid, y
    );

    modport slave (
        input  in_valid, a, b, is_signed, out_ready,
        output in_ready, out_valid, y
    );

endinterface

// File: rtl/cond_neg.sv
// Conditional two's-complement negate, used for operand magnitudes
// and for restoring the sign of the final product.
module cond_neg #(parameter int N = 8) (
    input  logic         neg,
    input  logic [N-1:0] x,
    output logic [N-1:0] y
);

    assign y = neg ? (~x + N'(1)) : x;

endmodule

// File: rtl/mult_seq.sv
// Sequential shift-add multiplier, one partial-product row per clock.
// Signed ops multiply magnitudes and negate the result when signs differ.
module mult_seq
    import mult_pkg::*;
#(
    parameter int W = 8
) (
    input  logic        clk,
    input  logic        rst,
    mult_seq_if.slave   bus
);

    localparam int CW = cnt_w(W);

    mult_state_t      state;
    logic [2*W-1:0]   mc;
    logic [W-1:0]     mp;
    logic [2*W-1:0]   acc;
    logic [CW-1:0]    cnt;
    logic             neg;
    logic             rdy_q;
    logic             vld_q;
    logic [2*W-1:0]   y_q;

    logic [W-1:0]     a_mag;
    logic [W-1:0]     b_mag;
    logic [2*W-1:0]   acc_nx;
    logic [2*W-1:0]   y_nx;
    logic             neg_a;
    logic             neg_b;

    assign neg_a = bus.is_signed & bus.a[W-1];
    assign neg_b = bus.is_signed & bus.b[W-1];

    cond_neg #(.N(W)) u_neg_a (
        .neg (neg_a),
        .x   (bus.a),
        .y   (a_mag)
    );

    cond_neg #(.N(W)) u_neg_b (
        .neg (neg_b),
        .x   (bus.b),
        .y   (b_mag)
    );

    assign acc_nx = acc + (mp[0] ? mc : '0);

    cond_neg #(.N(2*W)) u_neg_y (
        .neg (neg),
        .x   (acc_nx),
        .y   (y_nx)
    );

    assign bus.in_ready  = rdy_q;
    assign bus.out_valid = vld_q;
    assign bus.y         = y_q;

    // Control FSM with datapath registers; handshake outputs are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            rdy_q <= 1'b1;
            vld_q <= 1'b0;
            y_q   <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            mc    <= '0;
            mp    <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        mc    <= {{W{1'b0}}, a_mag};
                        mp    <= b_mag;
                        neg   <= neg_a ^ neg_b;
                        acc   <= '0;
                        cnt   <= CW'(W - 1);
                        rdy_q <= 1'b0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc <= acc_nx;
                    mc  <= mc << 1;
                    mp  <= mp >> 1;
                    cnt <= cnt - CW'(1);
                    if (cnt == '0) begin
                        y_q   <= y_nx;
                        vld_q <= 1'b1;
                        state <= DONE;
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        vld_q <= 1'b0;
                        rdy_q <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: begin
                    vld_q <= 1'b0;
                    rdy_q <= 1'b1;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq.sv
// Self-checking bench for mult_seq at W=8 (directed) and W=16 (random).
// Expected products come from plain integer arithmetic in the bench.
module tb_mult_seq;

    logic clk;
    logic rst;

    int checks;
    int failures;

    mult_seq_if #(.W(8))  if8 ();
    mult_seq_if #(.W(16)) if16 ();

    mult_seq #(.W(8)) u8 (
        .clk (clk),
        .rst (rst),
        .bus (if8.slave)
    );

    mult_seq #(.W(16)) u16 (
        .clk (clk),
        .rst (rst),
        .bus (if16.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  a;
        logic [7:0]  b;
        logic        s;
        logic [15:0] exp;
    } vec_t;

    vec_t tbl[12];

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ref16(input logic [15:0] a,
                                          input logic [15:0] b,
                                          input logic s);
        longint x;
        longint z;
        x = s ? longint'($signed(a)) : longint'(a);
        z = s ? longint'($signed(b)) : longint'(b);
        return 32'(x * z);
    endfunction

    task automatic op8(input logic [7:0] a, input logic [7:0] b,
                       input logic s, output logic [15:0] y,
                       output int lat);
        int n;
        @(negedge clk);
        n = 0;
        while (!if8.in_ready && n < 40) begin
            @(negedge clk);
            n++;
        end
        if8.a = a;
        if8.b = b;
        if8.is_signed = s;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        lat = 0;
        while (!if8.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        y = if8.y;
    endtask

    initial begin
        logic [15:0] y8;
        logic [15:0] y_hold;
        int lat;
        int bad;

        checks = 0;
        failures = 0;

        tbl[0]  = '{8'd3,   8'd5,   1'b0, 16'd15};
        tbl[1]  = '{8'h80,  8'h80,  1'b1, 16'h4000};
        tbl[2]  = '{8'hFF,  8'h7F,  1'b1, 16'hFF81};
        tbl[3]  = '{8'h7F,  8'h80,  1'b1, 16'hC080};
        tbl[4]  = '{8'hFF,  8'hFF,  1'b0, 16'hFE01};
        tbl[5]  = '{8'hFF,  8'hFF,  1'b1, 16'h0001};
        tbl[6]  = '{8'h00,  8'h55,  1'b0, 16'h0000};
        tbl[7]  = '{8'h55,  8'h00,  1'b1, 16'h0000};
        tbl[8]  = '{8'h80,  8'h01,  1'b1, 16'hFF80};
        tbl[9]  = '{8'h80,  8'h80,  1'b0, 16'h4000};
        tbl[10] = '{8'hFE,  8'h05,  1'b1, 16'hFFF6};
        tbl[11] = '{8'hFE,  8'h05,  1'b0, 16'h04F6};

        rst = 1'b1;
        if8.in_valid = 1'b0;
        if8.a = '0;
        if8.b = '0;
        if8.is_signed = 1'b0;
        if8.out_ready = 1'b1;
        if16.in_valid = 1'b0;
        if16.a = '0;
        if16.b = '0;
        if16.is_signed = 1'b0;
        if16.out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", 64'(if8.in_ready), 64'd1);
        chk("rst_out_valid", 64'(if8.out_valid), 64'd0);
        chk("rst_y", 64'(if8.y), 64'd0);
        chk("rst16_in_ready", 64'(if16.in_ready), 64'd1);
        rst = 1'b0;

        // Directed vector table, out_ready held high.
        for (int i = 0; i < 12; i++) begin
            op8(tbl[i].a, tbl[i].b, tbl[i].s, y8, lat);
            chk($sformatf("tbl%0d_lat", i), 64'(lat), 64'd8);
            chk($sformatf("tbl%0d_y", i), 64'(y8), 64'(tbl[i].exp));
            @(posedge clk);
            #1;
            chk($sformatf("tbl%0d_idle_rdy", i), 64'(if8.in_ready), 64'd1);
            chk($sformatf("tbl%0d_idle_vld", i), 64'(if8.out_valid), 64'd0);
        end

        // Backpressure with ignored in_valid pulses in CALC and DONE.
        if8.out_ready = 1'b0;
        @(negedge clk);
        if8.a = 8'd10;
        if8.b = 8'd12;
        if8.is_signed = 1'b0;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        @(posedge clk);
        #1;
        if8.a = 8'h33;
        if8.b = 8'h44;
        if8.in_valid = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        lat = 3;
        while (!if8.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("bp_lat", 64'(lat), 64'd8);
        chk("bp_y", 64'(if8.y), 64'd120);
        y_hold = if8.y;
        for (int k = 0; k < 5; k++) begin
            if8.in_valid = (k == 2);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold%0d_y", k), 64'(if8.y), 64'(y_hold));
            chk($sformatf("bp_hold%0d_vld", k), 64'(if8.out_valid), 64'd1);
            chk($sformatf("bp_hold%0d_rdy", k), 64'(if8.in_ready), 64'd0);
        end
        if8.in_valid = 1'b0;
        if8.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_rel_rdy", 64'(if8.in_ready), 64'd1);
        chk("bp_rel_vld", 64'(if8.out_valid), 64'd0);
        @(posedge clk);
        #1;
        chk("bp_noqueue_rdy", 64'(if8.in_ready), 64'd1);
        op8(8'd9, 8'd9, 1'b0, y8, lat);
        chk("bp_next_y", 64'(y8), 64'd81);
        chk("bp_next_lat", 64'(lat), 64'd8);
        @(posedge clk);
        #1;

        // Reset on the fourth CALC edge aborts the op.
        @(negedge clk);
        if8.a = 8'd100;
        if8.b = 8'd100;
        if8.is_signed = 1'b0;
        if8.in_valid = 1'b1;
        @(posedge clk);
        #1;
        if8.in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("abort_rdy", 64'(if8.in_ready), 64'd1);
        chk("abort_vld", 64'(if8.out_valid), 64'd0);
        chk("abort_y", 64'(if8.y), 64'd0);
        bad = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk);
            #1;
            if (if8.out_valid || if8.y != 16'd0) bad++;
        end
        chk("abort_quiet", 64'(bad), 64'd0);
        op8(8'd6, 8'd7, 1'b0, y8, lat);
        chk("abort_next_y", 64'(y8), 64'd42);
        chk("abort_next_lat", 64'(lat), 64'd8);
        @(posedge clk);
        #1;

        // W=16 randomized sweep against the arithmetic reference.
        for (int n = 0; n < 1000; n++) begin
            logic [15:0] ra;
            logic [15:0] rb;
            logic        rs;
            logic [31:0] exp;
            int          lt;
            int          gap;
            int          sel;

            sel = $urandom_range(0, 7);
            ra = 16'($urandom);
            rb = 16'($urandom);
            if (sel == 0) ra = 16'h8000;
            if (sel == 1) rb = 16'hFFFF;
            if (sel == 2) ra = 16'h0000;
            if (sel == 3) begin
                ra = 16'h8000;
                rb = 16'h8000;
            end
            if (sel == 4) rb = 16'h7FFF;
            rs = 1'($urandom);
            exp = ref16(ra, rb, rs);

            gap = $urandom_range(0, 3);
            repeat (gap) @(negedge clk);
            @(negedge clk);
            if16.a = ra;
            if16.b = rb;
            if16.is_signed = rs;
            if16.out_ready = 1'($urandom);
            if16.in_valid = 1'b1;
            @(posedge clk);
            #1;
            if16.in_valid = 1'($urandom);
            if16.a = 16'($urandom);
            lt = 0;
            while (!if16.out_valid && lt < 40) begin
                @(posedge clk);
                #1;
                lt++;
                if16.in_valid = 1'b0;
                if16.out_ready = 1'b0;
            end
            chk($sformatf("r%0d_lat", n), 64'(lt), 64'd16);
            chk($sformatf("r%0d_y", n), 64'(if16.y), 64'(exp));
            gap = $urandom_range(0, 3);
            repeat (gap) begin
                @(posedge clk);
                #1;
            end
            chk($sformatf("r%0d_hold", n), 64'(if16.y), 64'(exp));
            if16.out_ready = 1'b1;
            @(posedge clk);
            #1;
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mult_seq.md
# mult_seq

Parametrised sequential shift-add multiplier with valid/ready handshakes on input and output. Each operation is selectable as signed (two's complement) or unsigned. It is the area-optimised successor to the team's combinational 8-bit signed multiplier: it produces one partial-product row per clock instead of an adder tree. It sits inside the complex multiplier datapath, where four instances, or one time-shared instance, form the real/imaginary products.

## Interface
Parameters:
- `W`, default 8: operand width in bits. Legal range 2 to 32. Result width is 2·W.

Ports:
- `clk`, in, 1: sole clock; all state changes on its rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `in_valid`, in, 1: operands and mode are valid.
- `in_ready`, out, 1: block can accept an operation.
- `a`, in, W: multiplicand.
- `b`, in, W: multiplier.
- `is_signed`, in, 1: 1 means treat `a`/`b` as two's complement; 0 means unsigned. Sampled only at accept.
- `out_valid`, out, 1: `y` holds a completed product.
- `out_ready`, in, 1: consumer takes `y`.
- `y`, out, 2W: product, two's complement if the op was signed.

## Operation
- States: IDLE, CALC, DONE.
- IDLE:
  - `in_ready`=1.
  - Accept occurs on an edge where `in_valid && in_ready`.
  - At accept, the block registers the operand magnitudes, computed as follows:
    - If `is_signed` and the MSB is set, the magnitude is `~x+1`, held as W-bit unsigned. -2^(W-1) therefore becomes 2^(W-1), which is correct.
    - Otherwise the operand is used as is.
  - At accept, the block also registers `neg = is_signed & (a[W-1] ^ b[W-1])`, clears the 2W-bit accumulator, loads the bit counter with W-1, and moves to CALC.
- CALC, once per cycle:
  - If the current LSB of the multiplier-magnitude shift register is 1, add (multiplicand magnitude << step) into the accumulator.
  - Then shift the multiplier register right by one and decrement the counter.
  - The step with counter = 0 is the last one. On that edge, write `y = neg ? ~acc_final+1 : acc_final` and move to DONE.
  - Sign handling follows the negate / unsigned multiply / negate-result scheme of the existing 8-bit block.
- DONE:
  - `out_valid`=1 and `y` is held stable.
  - On an edge with `out_ready` high, go to IDLE.
  - `in_ready` is 0 in DONE; a new op cannot be accepted in the same cycle as the output handshake.
- Width rules:
  - The accumulator and `y` are 2W bits; no overflow is possible. The extreme case is (-2^(W-1))² = 2^(2W-2), which is representable.
  - Unsigned max: (2^W-1)² fits in 2W bits.
- Zero operands still take the full W CALC cycles. Latency is fixed and data-independent.
- `in_valid` asserted in CALC or DONE is ignored and does not queue. Upstream must hold it until `in_ready`.

## Timing
- Reset values, with reset taking priority over every transition in every state:
  - state = IDLE
  - `in_ready`=1
  - `out_valid`=0
  - `y`=0
  - accumulator, counter and `neg` = 0
- Reset during CALC or DONE aborts the operation. The cycle after reset shows the reset values, and the aborted result is never presented.
- Latency:
  - Accept at edge N.
  - CALC occupies edges N+1 … N+W.
  - `out_valid` rises after edge N+W.
  - Minimum issue interval is W+2 cycles (accept, W calc, one DONE cycle with `out_ready`=1).
- `y` is registered and changes only on the CALC→DONE edge and on reset. There is no combinational path from `a`/`b` to `y`.
- `in_ready` and `out_valid` are decoded from registered state only. There is no combinational path from `in_valid` or `out_ready`.

## Structure
- Shared package `mult_pkg`:
  - `typedef enum logic [1:0] {IDLE, CALC, DONE} mult_state_t`
  - localparam helper for the counter width: `$clog2(W)`, minimum 1.
- Sub-module `cond_neg #(N)`: combinational conditional two's-complement negate (`neg ? ~x+1 : x`). It is instantiated twice at W bits for the operands and once at 2W bits for the result.
- Everything else lives in `mult_seq`.

## Test plan
All cases use W=8 unless stated.
- Unsigned 3×5 with `out_ready`=1 → `out_valid` exactly 8 cycles after accept; y=15; back to IDLE one cycle later.
- Signed -128×-128 → y=0x4000. Signed -1×127 → y=0xFF81. Signed 127×-128 → y=0xC080.
- Unsigned 255×255 → y=0xFE01. The same bits signed (-1×-1) → y=0x0001.
- Backpressure:
  - Hold `out_ready`=0 for 5 cycles in DONE → y and `out_valid` stay stable and `in_ready`=0.
  - `in_valid` pulsed during CALC/DONE is ignored.
  - After release, the next op is accepted and computed correctly.
- Reset asserted on the 4th CALC cycle → next cycle `in_ready`=1, `out_valid`=0, y=0; a following 6×7 yields 42.
- W=16 random signed/unsigned sweep (≥1000 ops, random `in_valid`/`out_ready` gaps) → every y matches the reference model, and latency is always 16.
